fetch_control: RTL and testbench

- Sequencer on the far side of program_counter: consumes the PC value (`result`) and fetches the instruction at that address from instruction memory.
- Decodes control-flow opcodes and drives the program counter's enable, jump, jz and jump_address inputs.
- Hands every non-control instruction to the execute stage through a valid/ready handshake.
- Sits between program_counter, instruction memory and the ALU/execute datapath of the 8-bit CPU.

---
 rtl/cpu_pkg.sv | 31 +++
 rtl/fetch_control_if.sv | 23 ++
 rtl/instr_decode.sv | 20 ++
 rtl/fetch_control.sv | 140 ++++++++++++++
 tb/tb_fetch_control.sv | 346 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU front end: opcodes, sequencer states,
// opcode classes and instruction field positions.
package cpu_pkg;

    localparam int OPCODE_W  = 4;
    localparam int ADDR_LSB  = 0;
    localparam int RETIRED_W = 16;

    localparam logic [OPCODE_W-1:0] OP_NOP  = 4'h0;
    localparam logic [OPCODE_W-1:0] OP_HALT = 4'hD;
    localparam logic [OPCODE_W-1:0] OP_JMP  = 4'hE;
    localparam logic [OPCODE_W-1:0] OP_JZ   = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_DECODE  = 3'd2,
        ST_ISSUE   = 3'd3,
        ST_ADVANCE = 3'd4,
        ST_HALT    = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        CLS_NOP  = 3'd0,
        CLS_JMP  = 3'd1,
        CLS_JZ   = 3'd2,
        CLS_HALT = 3'd3,
        CLS_ALU  = 3'd4
    } op_class_t;

endpackage

// File: rtl/fetch_control_if.sv
// Instruction-memory read port and execute-stage issue handshake of the fetch sequencer.
interface fetch_control_if #(
    parameter int WORD_WIDTH  = 8,
    parameter int INSTR_WIDTH = 16
);
    logic                   mem_req;
    logic [WORD_WIDTH-1:0]  mem_addr;
    logic                   mem_ready;
    logic [INSTR_WIDTH-1:0] mem_data;
    logic [INSTR_WIDTH-1:0] instr;
    logic                   instr_valid;
    logic                   exec_ready;

    modport master (
        output mem_req, mem_addr, instr, instr_valid,
        input  mem_ready, mem_data, exec_ready
    );

    modport slave (
        input  mem_req, mem_addr, instr, instr_valid,
        output mem_ready, mem_data, exec_ready
    );
endinterface

// File: rtl/instr_decode.sv
// Combinational opcode classifier, shared by the fetch sequencer and the execute stage.
module instr_decode
    import cpu_pkg::*;
(
    input  logic [OPCODE_W-1:0] opcode,
    output op_class_t           op_class
);

    always_comb begin
        op_class = CLS_ALU;
        unique case (opcode)
            OP_NOP:  op_class = CLS_NOP;
            OP_JMP:  op_class = CLS_JMP;
            OP_JZ:   op_class = CLS_JZ;
            OP_HALT: op_class = CLS_HALT;
            default: op_class = CLS_ALU;
        endcase
    end

endmodule

// File: rtl/fetch_control.sv
// Fetch/decode sequencer: reads the instruction at the current PC, steers the
// program counter for control-flow opcodes and issues everything else to execute.
module fetch_control
    import cpu_pkg::*;
#(
    parameter int WORD_WIDTH  = 8,
    parameter int INSTR_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    fetch_control_if.master       bus,
    input  logic [WORD_WIDTH-1:0] pc,
    output logic                  pc_enable,
    output logic                  pc_jump,
    output logic                  pc_jz,
    output logic [WORD_WIDTH-1:0] jump_address,
    output logic                  halted,
    output logic [RETIRED_W-1:0]  retired
);

    state_t                   state_q, state_d;
    logic [INSTR_WIDTH-1:0]   ir_q, ir_d;
    logic                     jmp_flag_q, jmp_flag_d;
    logic                     jz_flag_q, jz_flag_d;
    logic [RETIRED_W-1:0]     retired_q, retired_d;
    logic                     mem_req_q, mem_req_d;
    logic                     instr_valid_q, instr_valid_d;
    logic                     pc_enable_q, pc_enable_d;
    logic                     pc_jump_q, pc_jump_d;
    logic                     pc_jz_q, pc_jz_d;
    logic [WORD_WIDTH-1:0]    jump_address_q, jump_address_d;
    logic                     halted_q, halted_d;
    op_class_t                op_class;

    function automatic logic [RETIRED_W-1:0] sat_inc(input logic [RETIRED_W-1:0] v);
        return (v == {RETIRED_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    instr_decode u_decode (
        .opcode   (ir_q[INSTR_WIDTH-1 -: OPCODE_W]),
        .op_class (op_class)
    );

    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        jmp_flag_d = jmp_flag_q;
        jz_flag_d  = jz_flag_q;
        retired_d  = retired_q;

        unique case (state_q)
            ST_IDLE: state_d = ST_FETCH;
            ST_FETCH: begin
                if (bus.mem_ready) begin
                    ir_d    = bus.mem_data;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                unique case (op_class)
                    CLS_NOP:  state_d = ST_ADVANCE;
                    CLS_JMP: begin
                        jmp_flag_d = 1'b1;
                        state_d    = ST_ADVANCE;
                    end
                    CLS_JZ: begin
                        jz_flag_d = 1'b1;
                        state_d   = ST_ADVANCE;
                    end
                    CLS_HALT: state_d = ST_HALT;
                    default:  state_d = ST_ISSUE;
                endcase
            end
            ST_ISSUE: begin
                if (bus.exec_ready) state_d = ST_ADVANCE;
            end
            ST_ADVANCE: begin
                retired_d  = sat_inc(retired_q);
                jmp_flag_d = 1'b0;
                jz_flag_d  = 1'b0;
                state_d    = ST_FETCH;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase

        // Outputs are registered against the state being entered, so each one is a flop.
        mem_req_d      = (state_d == ST_FETCH);
        instr_valid_d  = (state_d == ST_ISSUE);
        pc_enable_d    = (state_d == ST_ADVANCE);
        pc_jump_d      = (state_d == ST_ADVANCE) && jmp_flag_d;
        pc_jz_d        = (state_d == ST_ADVANCE) && jz_flag_d;
        jump_address_d = (state_d == ST_ADVANCE) ? ir_d[ADDR_LSB +: WORD_WIDTH] : '0;
        halted_d       = (state_d == ST_HALT);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            ir_q           <= '0;
            jmp_flag_q     <= 1'b0;
            jz_flag_q      <= 1'b0;
            retired_q      <= '0;
            mem_req_q      <= 1'b0;
            instr_valid_q  <= 1'b0;
            pc_enable_q    <= 1'b0;
            pc_jump_q      <= 1'b0;
            pc_jz_q        <= 1'b0;
            jump_address_q <= '0;
            halted_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            ir_q           <= ir_d;
            jmp_flag_q     <= jmp_flag_d;
            jz_flag_q      <= jz_flag_d;
            retired_q      <= retired_d;
            mem_req_q      <= mem_req_d;
            instr_valid_q  <= instr_valid_d;
            pc_enable_q    <= pc_enable_d;
            pc_jump_q      <= pc_jump_d;
            pc_jz_q        <= pc_jz_d;
            jump_address_q <= jump_address_d;
            halted_q       <= halted_d;
        end
    end

    // pc is itself the program counter's register; it is only gated onto the
    // address bus so that FETCH sees the value written on the edge ending ADVANCE.
    assign bus.mem_req     = mem_req_q;
    assign bus.mem_addr    = mem_req_q ? pc : '0;
    assign bus.instr       = ir_q;
    assign bus.instr_valid = instr_valid_q;
    assign pc_enable       = pc_enable_q;
    assign pc_jump         = pc_jump_q;
    assign pc_jz           = pc_jz_q;
    assign jump_address    = jump_address_q;
    assign halted          = halted_q;
    assign retired         = retired_q;

endmodule

// File: tb/tb_fetch_control.sv
// Bench for fetch_control: program-level reference model feeds expectation queues,
// a monitor pops and compares against what the sequencer presents.
module tb_fetch_control;

    logic        clock;
    logic        reset;
    logic [7:0]  pc_r;
    logic        pc_enable, pc_jump, pc_jz, halted;
    logic [7:0]  jump_address;
    logic [15:0] retired;

    fetch_control_if #(.WORD_WIDTH(8), .INSTR_WIDTH(16)) bus ();

    fetch_control #(.WORD_WIDTH(8), .INSTR_WIDTH(16)) dut (
        .clock        (clock),
        .reset        (reset),
        .bus          (bus),
        .pc           (pc_r),
        .pc_enable    (pc_enable),
        .pc_jump      (pc_jump),
        .pc_jz        (pc_jz),
        .jump_address (jump_address),
        .halted       (halted),
        .retired      (retired)
    );

    typedef struct packed {
        logic       alu;
        logic       jmp;
        logic       jz;
        logic [7:0] addr;
    } adv_t;

    logic [15:0] prog [256];
    bit          zf   [256];
    logic [7:0]  fetch_q [$];
    logic [15:0] issue_q [$];
    adv_t        adv_q   [$];

    int   checks = 0;
    int   failures = 0;
    bit   mon_halt_exp = 0;
    bit   rand_mode = 0;
    bit   halt_toggle = 0;
    int   mem_wait_cfg = 0;
    int   exec_wait_cfg = 0;
    int   adv_cnt;
    int   model_nadv;
    logic [7:0] model_final_pc;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign bus.mem_data = bus.mem_ready ? prog[bus.mem_addr] : 16'hDEAD;

    // Environment program counter: behaves like the real program_counter block.
    always @(posedge clock) begin
        if (reset) begin
            pc_r    <= 8'h00;
            adv_cnt <= 0;
        end else if (pc_enable) begin
            if (pc_jump || (pc_jz && zf[adv_cnt])) pc_r <= jump_address;
            else                                   pc_r <= pc_r + 8'h01;
            adv_cnt <= adv_cnt + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        checks++;
        failures++;
        $display("FAIL %s actual=0x%0h expected=no event at %0t", name, act, $time);
    endtask

    task automatic chk_zero(input string tag);
        check({tag, "_mem_req"},      32'(bus.mem_req), 0);
        check({tag, "_mem_addr"},     32'(bus.mem_addr), 0);
        check({tag, "_pc_enable"},    32'(pc_enable), 0);
        check({tag, "_pc_jump"},      32'(pc_jump), 0);
        check({tag, "_pc_jz"},        32'(pc_jz), 0);
        check({tag, "_jump_address"}, 32'(jump_address), 0);
        check({tag, "_instr"},        32'(bus.instr), 0);
        check({tag, "_instr_valid"},  32'(bus.instr_valid), 0);
        check({tag, "_halted"},       32'(halted), 0);
        check({tag, "_retired"},      32'(retired), 0);
    endtask

    // Reference model: walks the program by instruction semantics, not by cycles.
    task automatic build_model(input int n);
        logic [7:0]  p;
        logic [15:0] ins;
        logic [3:0]  op;
        bit          ctl;
        fetch_q.delete();
        issue_q.delete();
        adv_q.delete();
        mon_halt_exp = 0;
        model_nadv   = 0;
        p = 8'h00;
        for (int i = 0; i < n; i++) begin
            ins = prog[p];
            op  = ins[15:12];
            fetch_q.push_back(p);
            if (op == 4'hD) begin
                mon_halt_exp = 1;
                break;
            end
            ctl = (op == 4'h0) || (op == 4'hE) || (op == 4'hF);
            if (!ctl) issue_q.push_back(ins);
            adv_q.push_back('{alu: !ctl, jmp: (op == 4'hE), jz: (op == 4'hF), addr: ins[7:0]});
            model_nadv++;
            if (op == 4'hE || (op == 4'hF && zf[i])) p = ins[7:0];
            else                                     p = p + 8'h01;
        end
        model_final_pc = p;
    endtask

    // Memory and execute-stage responder.
    initial begin
        int wcnt = 0;
        int ecnt = 0;
        bus.mem_ready  = 1'b0;
        bus.exec_ready = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            if (reset) begin
                wcnt = 0;
                ecnt = 0;
                bus.mem_ready  = 1'b0;
                bus.exec_ready = 1'b0;
            end else if (halt_toggle) begin
                bus.mem_ready  = 1'($urandom);
                bus.exec_ready = 1'($urandom);
            end else begin
                if (bus.mem_req && fetch_q.size() > 0) begin
                    bus.mem_ready = rand_mode ? ($urandom_range(0, 2) != 0) : (wcnt == mem_wait_cfg);
                    wcnt = bus.mem_ready ? 0 : wcnt + 1;
                end else begin
                    bus.mem_ready = (rand_mode && !bus.mem_req) ? 1'($urandom) : 1'b0;
                    wcnt = 0;
                end
                if (bus.instr_valid) begin
                    bus.exec_ready = rand_mode ? 1'($urandom) : (ecnt == exec_wait_cfg);
                    ecnt = bus.exec_ready ? 0 : ecnt + 1;
                end else begin
                    bus.exec_ready = rand_mode ? 1'($urandom) : 1'b0;
                    ecnt = 0;
                end
            end
        end
    end

    // Monitor / scoreboard.
    initial begin
        int          cyc = 0;
        int          last_hs = 0;
        int          req_run = 0;
        int          adv_done = 0;
        bit          prev_valid = 0;
        logic [15:0] prev_instr = '0;
        logic [7:0]  ea;
        logic [15:0] ei;
        adv_t        a;
        forever begin
            @(negedge clock);
            if (reset) begin
                cyc = 0; last_hs = 0; req_run = 0; adv_done = 0; prev_valid = 0;
            end else begin
                cyc++;
                if (bus.mem_req) req_run++;
                if (bus.mem_req && bus.mem_ready) begin
                    if (fetch_q.size() == 0) unexpected("fetch_unexpected", 32'(bus.mem_addr));
                    else begin
                        ea = fetch_q.pop_front();
                        check("fetch_addr", 32'(bus.mem_addr), 32'(ea));
                        if (!rand_mode && !halt_toggle)
                            check("mem_req_cycles", 32'(req_run), 32'(mem_wait_cfg + 1));
                    end
                    req_run = 0;
                    last_hs = cyc;
                end
                if (bus.instr_valid) begin
                    if (prev_valid) check("instr_stable", 32'(bus.instr), 32'(prev_instr));
                    if (bus.exec_ready) begin
                        if (issue_q.size() == 0) unexpected("issue_unexpected", 32'(bus.instr));
                        else begin
                            ei = issue_q.pop_front();
                            check("issue_instr", 32'(bus.instr), 32'(ei));
                        end
                        last_hs = cyc;
                        prev_valid = 0;
                    end else begin
                        prev_valid = 1;
                        prev_instr = bus.instr;
                    end
                end else if (prev_valid) begin
                    unexpected("instr_valid_dropped", 32'(prev_instr));
                    prev_valid = 0;
                end
                if (pc_enable) begin
                    if (adv_q.size() == 0) unexpected("advance_unexpected", 32'(jump_address));
                    else begin
                        a = adv_q.pop_front();
                        check("adv_pc_jump", 32'(pc_jump), 32'(a.jmp));
                        check("adv_pc_jz", 32'(pc_jz), 32'(a.jz));
                        check("adv_jump_address", 32'(jump_address), 32'(a.addr));
                        check("adv_latency", 32'(cyc - last_hs), a.alu ? 32'd1 : 32'd2);
                        check("retired_at_adv", 32'(retired), 32'(adv_done));
                    end
                    adv_done++;
                end else begin
                    check("jump_flags_outside_adv", {30'd0, pc_jump, pc_jz}, 32'd0);
                    check("jump_addr_outside_adv", 32'(jump_address), 32'd0);
                end
                if (halted) check("halt_expected", 32'(mon_halt_exp), 32'd1);
            end
        end
    end

    task automatic run_phase(input string tag, input int n, input int max_cycles);
        bit done = 0;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        build_model(n);
        #1 reset = 1'b0;
        for (int c = 0; c < max_cycles && !done; c++) begin
            @(posedge clock);
            #1;
            done = (fetch_q.size() == 0) && (issue_q.size() == 0) && (adv_q.size() == 0) &&
                   (!mon_halt_exp || halted);
        end
        if (!done) unexpected({tag, "_timeout_pending"}, 32'(fetch_q.size() + issue_q.size() + adv_q.size()));
        @(negedge clock);
        check({tag, "_retired_final"}, 32'(retired), 32'(model_nadv));
        if (!mon_halt_exp) begin
            check({tag, "_next_fetch_req"}, 32'(bus.mem_req), 32'd1);
            check({tag, "_next_fetch_addr"}, 32'(bus.mem_addr), 32'(model_final_pc));
        end
    endtask

    function automatic logic [15:0] rand_instr();
        logic [3:0] op;
        case ($urandom_range(0, 7))
            0:       op = 4'h0;
            1:       op = 4'hE;
            2:       op = 4'hF;
            default: op = 4'($urandom_range(1, 12));
        endcase
        return {op, 12'($urandom)};
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog_expired time=%0t expected=finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        for (int i = 0; i < 256; i++) begin
            prog[i] = 16'h0000;
            zf[i]   = 1'b0;
        end
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk_zero("reset");

        // Zero-wait NOP at 0x00.
        prog[0] = 16'h0000;
        run_phase("nop", 1, 50);

        // DUT now sits in FETCH with mem_ready low; reset it there.
        @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk_zero("midfetch_reset");
        @(negedge clock);
        check("refetch_mem_req", 32'(bus.mem_req), 32'd1);
        check("refetch_mem_addr", 32'(bus.mem_addr), 32'd0);

        // JMP at 0x05 to 0x3C.
        for (int i = 0; i < 5; i++) prog[i] = {4'h0, 12'(i * 17)};
        prog[5]     = 16'hE03C;
        prog[8'h3C] = 16'h0077;
        run_phase("jmp", 7, 100);

        // JZ taken then JZ not taken, memory wait 2.
        prog[0]     = 16'hF010;
        prog[8'h10] = 16'h0001;
        prog[8'h11] = 16'hF020;
        zf[0] = 1'b1; zf[1] = 1'b0; zf[2] = 1'b0;
        mem_wait_cfg = 2;
        run_phase("jz", 3, 100);
        mem_wait_cfg = 0;

        // ALU op held by execute for 4 cycles.
        prog[0] = 16'h3A12;
        exec_wait_cfg = 4;
        run_phase("alu", 1, 100);
        exec_wait_cfg = 0;

        // HALT, then wiggle the handshakes.
        prog[0] = 16'hD000;
        run_phase("halt", 1, 100);
        halt_toggle = 1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            check("halt_halted", 32'(halted), 32'd1);
            check("halt_mem_req", 32'(bus.mem_req), 32'd0);
            check("halt_pc_enable", 32'(pc_enable), 32'd0);
            check("halt_instr_valid", 32'(bus.instr_valid), 32'd0);
        end
        halt_toggle = 0;
        @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk_zero("halt_reset");

        // Random programs with random memory and execute back-pressure.
        rand_mode = 1;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 256; i++) begin
                prog[i] = rand_instr();
                zf[i]   = 1'($urandom);
            end
            run_phase("random", 60, 3000);
        end
        rand_mode = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
